// File: rtl/sensor_source_selector.sv
// N-channel sensor sample selector: keeps the latest sample of every channel and forwards
// the active one as a valid-qualified stream, with manual/auto-scan choice and a debounced alarm.
module sensor_source_selector #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_CYC   = 50000000,
  parameter int SETTLE_CYC = 4,
  parameter int ALARM_CNT  = 3,
  localparam int SEL_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        alarm_thresh,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  output logic                     alarm
);

  localparam int SCAN_W   = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;
  localparam int SETTLE_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int ALARM_W  = $clog2(ALARM_CNT + 1);

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_CYC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [ALARM_W-1:0]  ALARM_FULL  = ALARM_W'(ALARM_CNT);
  localparam logic [SEL_W-1:0]    LAST_CH     = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]      NUM_CH_EXT  = (SEL_W + 1)'(NUM_CH);

  typedef enum logic {ST_SETTLE, ST_RUN} state_t;

  logic [DATA_W-1:0]   ch_slice  [NUM_CH];
  logic [DATA_W-1:0]   hold_view [NUM_CH];

  state_t              state_reg;
  logic [SEL_W-1:0]    active_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic [SCAN_W-1:0]   scan_cnt_reg;
  logic [ALARM_W-1:0]  alarm_cnt_reg;

  logic [SEL_W-1:0]    scan_next_ch;
  logic [SEL_W-1:0]    target_ch;
  logic                scan_wrap;
  logic                sel_ok;
  logic                switch_now;
  logic                act_strobe;
  logic [DATA_W-1:0]   pub_value;
  logic                pub_fire;
  logic                over_thresh;
  logic [ALARM_W-1:0]  alarm_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] hold_reg;

      assign ch_slice[gi] = ch_data[gi*DATA_W +: DATA_W];

      // Every channel keeps its newest sample whether or not it is being shown.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hold_reg <= '0;
        end else if (ch_valid[gi]) begin
          hold_reg <= ch_slice[gi];
        end
      end

      assign hold_view[gi] = hold_reg;
    end
  endgenerate

  assign scan_wrap    = (scan_cnt_reg == SCAN_LAST);
  assign scan_next_ch = (active_reg == LAST_CH) ? '0 : active_reg + SEL_W'(1);
  assign sel_ok       = ({1'b0, sel} < NUM_CH_EXT);

  always_comb begin
    target_ch = active_reg;
    if (mode) begin
      if (scan_wrap) begin
        target_ch = scan_next_ch;
      end
    end else if (sel_ok) begin
      target_ch = sel;
    end
  end

  assign switch_now = (target_ch != active_reg);
  assign act_strobe = ch_valid[active_reg];
  // A strobe arriving on the publish cycle is fresher than the hold register.
  assign pub_value  = act_strobe ? ch_slice[active_reg] : hold_view[active_reg];
  assign pub_fire   = !switch_now &&
                      (((state_reg == ST_SETTLE) && (settle_cnt_reg == SETTLE_LAST)) ||
                       ((state_reg == ST_RUN) && act_strobe));
  assign over_thresh    = (pub_value >= alarm_thresh);
  assign alarm_cnt_next = (alarm_cnt_reg == ALARM_FULL) ? alarm_cnt_reg
                                                        : alarm_cnt_reg + ALARM_W'(1);

  // Cleared while manual so that entering auto-scan always starts a fresh dwell period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_reg <= '0;
    end else if (!mode || scan_wrap) begin
      scan_cnt_reg <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_SETTLE;
      active_reg     <= '0;
      settle_cnt_reg <= '0;
      alarm_cnt_reg  <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      alarm          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (switch_now) begin
        active_reg     <= target_ch;
        state_reg      <= ST_SETTLE;
        settle_cnt_reg <= '0;
        alarm_cnt_reg  <= '0;
        alarm          <= 1'b0;
      end else begin
        if ((state_reg == ST_SETTLE) && (settle_cnt_reg != SETTLE_LAST)) begin
          settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
        end
        if (pub_fire) begin
          state_reg <= ST_RUN;
          out_data  <= pub_value;
          out_valid <= 1'b1;
          if (over_thresh) begin
            alarm_cnt_reg <= alarm_cnt_next;
            alarm         <= (alarm_cnt_next == ALARM_FULL);
          end else begin
            alarm_cnt_reg <= '0;
            alarm         <= 1'b0;
          end
        end
      end
    end
  end

  assign out_ch = active_reg;

endmodule

// File: tb/tb_sensor_source_selector.sv
// Directed bench for sensor_source_selector: 4-channel instance for the main behaviour and a
// 5-channel instance to exercise out-of-range manual selection.
module tb_sensor_source_selector;

  localparam int SETTLE = 4;

  logic        clk;
  logic        reset_n;
  logic [63:0] ch_data;
  logic [3:0]  ch_valid;
  logic [1:0]  sel;
  logic        mode;
  logic [15:0] alarm_thresh;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        alarm;

  logic [79:0] ch_data5;
  logic [4:0]  ch_valid5;
  logic [2:0]  sel5;
  logic        mode5;
  logic [15:0] thresh5;
  logic [15:0] out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;
  logic        alarm5;

  int checks;
  int failures;

  sensor_source_selector #(
    .NUM_CH(4), .DATA_W(16), .SCAN_CYC(8), .SETTLE_CYC(SETTLE), .ALARM_CNT(3)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_valid(ch_valid), .sel(sel),
    .mode(mode), .alarm_thresh(alarm_thresh), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .alarm(alarm)
  );

  sensor_source_selector #(
    .NUM_CH(5), .DATA_W(16), .SCAN_CYC(8), .SETTLE_CYC(SETTLE), .ALARM_CNT(3)
  ) u_dut5 (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data5), .ch_valid(ch_valid5), .sel(sel5),
    .mode(mode5), .alarm_thresh(thresh5), .out_data(out_data5), .out_ch(out_ch5),
    .out_valid(out_valid5), .alarm(alarm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int k, input logic [15:0] v);
    ch_data[k*16 +: 16] = v;
    ch_valid = 4'b0000;
    ch_valid[k] = 1'b1;
    $display("txn ch=%0d data=%04h", k, v);
    tick();
    ch_valid = 4'b0000;
  endtask

  // Called once the switch (or reset release) is visible: SETTLE quiet cycles, then one publish.
  task automatic settle_expect(input logic [15:0] d, input logic [1:0] c);
    chk("settle_ov0", out_valid, 0);
    chk("settle_ch", out_ch, c);
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      chk("settle_ov0", out_valid, 0);
    end
    tick();
    chk("pub_ov", out_valid, 1);
    chk("pub_data", out_data, d);
    chk("pub_ch", out_ch, c);
    tick();
    chk("pub_once", out_valid, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    ch_data = '0;
    ch_valid = '0;
    sel = 2'd0;
    mode = 1'b0;
    alarm_thresh = 16'hFFFF;
    ch_data5 = '0;
    ch_valid5 = '0;
    sel5 = 3'd0;
    mode5 = 1'b0;
    thresh5 = 16'h0000;

    repeat (2) tick();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_alarm", alarm, 0);
    reset_n = 1'b1;
    settle_expect(16'h0000, 2'd0);

    // Reset in the middle of an out_valid pulse clears everything at once.
    pulse(0, 16'h0AAA);
    chk("t1_ov", out_valid, 1);
    chk("t1_data", out_data, 16'h0AAA);
    reset_n = 1'b0;
    #1;
    chk("t1_async_data", out_data, 0);
    chk("t1_async_ov", out_valid, 0);
    chk("t1_async_ch", out_ch, 0);
    chk("t1_async_alarm", alarm, 0);
    tick();
    tick();
    reset_n = 1'b1;
    settle_expect(16'h0000, 2'd0);

    // Manual select of channel 2; other channels only update hold registers.
    sel = 2'd2;
    tick();
    settle_expect(16'h0000, 2'd2);
    pulse(1, 16'h0055);
    chk("t2_other_ch", out_valid, 0);
    pulse(2, 16'h0123);
    chk("t2_ov", out_valid, 1);
    chk("t2_data", out_data, 16'h0123);
    chk("t2_ch", out_ch, 2);
    tick();
    chk("t2_ov_pulse", out_valid, 0);

    sel = 2'd1;
    tick();
    settle_expect(16'h0055, 2'd1);
    chk("t3_alarm", alarm, 0);

    // Debounced alarm with saturation, then clear on a low sample.
    alarm_thresh = 16'd5;
    pulse(1, 16'd5);
    chk("t4_a1", alarm, 0);
    pulse(1, 16'd6);
    chk("t4_a2", alarm, 0);
    pulse(1, 16'd7);
    chk("t4_a3", alarm, 1);
    pulse(1, 16'd100);
    chk("t4_sat", alarm, 1);
    pulse(1, 16'd4);
    chk("t4_low_data", out_data, 4);
    chk("t4_low", alarm, 0);
    pulse(1, 16'd5);
    pulse(1, 16'd6);
    pulse(1, 16'd7);
    chk("t4_rearm", alarm, 1);
    sel = 2'd0;
    tick();
    chk("t4_switch_clr", alarm, 0);
    settle_expect(16'h0000, 2'd0);

    // Auto-scan: one step every 8 cycles starting from the current channel.
    mode = 1'b1;
    for (int s = 1; s <= 32; s++) begin
      tick();
      if ((s % 8) == 7) chk("t5_scan_hold", out_ch, (s / 8) % 4);
      if ((s % 8) == 0) chk("t5_scan_step", out_ch, (s / 8) % 4);
    end
    mode = 1'b0;
    sel = 2'd0;
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      chk("t5_back_ov0", out_valid, 0);
    end
    tick();
    chk("t5_back_ov", out_valid, 1);
    chk("t5_back_ch", out_ch, 0);
    tick();
    tick();

    // Out-of-range manual select on the 5-channel instance is ignored.
    sel5 = 3'd4;
    tick();
    chk("t5_sel_in_range", out_ch5, 4);
    sel5 = 3'd7;
    repeat (3) tick();
    chk("t5_sel7", out_ch5, 4);
    sel5 = 3'd5;
    tick();
    chk("t5_sel5", out_ch5, 4);
    sel5 = 3'd2;
    tick();
    chk("t5_sel2", out_ch5, 2);

    // Strobe on the active channel coincident with a switch: no output, sample kept.
    sel = 2'd3;
    ch_data[15:0] = 16'h0BEE;
    ch_valid = 4'b0001;
    $display("txn ch=0 data=0bee with switch to ch3");
    tick();
    ch_valid = 4'b0000;
    chk("t6_no_ov", out_valid, 0);
    chk("t6_ch", out_ch, 3);
    settle_expect(16'h0000, 2'd3);
    sel = 2'd0;
    tick();
    settle_expect(16'h0BEE, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
